shift_add_mul_sched: RTL and testbench

//  Shares one sequential shift-add multiplier between NUM_REQ requesters.
//  - Round-robin arbiter picks one requester and latches its operands.
//  - Iterative core does one partial-product add per cycle (bit i of b adds a<<i).
//  - Product is returned with the requester id over a valid/ready response port.
//  - Replaces per-requester combinational multipliers where area matters more than throughput.

---
 rtl/shift_add_mul_sched_pkg.sv | 21 ++
 rtl/shift_add_mul_sched_core.sv | 78 +++++++
 rtl/shift_add_mul_sched.sv | 126 ++++++++++++
 tb/tb_shift_add_mul_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mul_sched_pkg.sv
// Shared definitions for the shared shift-add multiplier: FSM state encoding
// and a constant clog2 used to size the requester-id and counter fields.
package shift_add_mul_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_add_mul_sched_core.sv
// Iterative unsigned multiplier: one partial-product add per cycle, WIDTH cycles
// per operation. prod carries the final sum on the cycle that done is high.
module shift_add_seq_core
  import shift_add_mul_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] sum;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    partial = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    sum     = acc_q + partial;
    if (load) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = sum;
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the async reset clears datapath registers too, so a reset mid-operation
  // leaves no stale partial product behind.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so all flops update from the same pre-edge values.
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_LAST);
  assign prod = sum;

endmodule

// File: rtl/shift_add_mul_sched.sv
// Round-robin front end sharing one shift-add multiplier among NUM_REQ requesters,
// returning each product with its requester id over a valid/ready port.
module shift_add_mul_sched
  import shift_add_mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_prod,
  output logic                     busy
);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0] rsp_prod_q, rsp_prod_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic               load;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic               core_busy, core_done;
  logic [2*WIDTH-1:0] core_prod;

  // Search starts at rr_ptr and wraps, so the last winner gets lowest priority.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign a_sel = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    load        = 1'b0;
    req_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          load      = 1'b1;
          id_d      = grant_idx;
          rr_ptr_d  = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        if (core_done) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_prod_d  = core_prod;
          rsp_id_d    = id_q;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
    end
  end

  shift_add_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (load),
    .a     (a_sel),
    .b     (b_sel),
    .busy  (core_busy),
    .done  (core_done),
    .prod  (core_prod)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign busy      = (state_q != ST_IDLE) || core_busy;

endmodule

// File: tb/tb_shift_add_mul_sched.sv
// Self-checking bench for shift_add_mul_sched: directed vector table, held
// round-robin sequence, stall and reset corner cases, randomized exhaustive sweep.
module tb_shift_add_mul_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int ID_W    = 2;
  localparam int PW      = 2 * WIDTH;

  logic                     clk = 1'b0;
  logic                     n_rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [PW-1:0]            rsp_prod;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    int                 a;
    int                 b;
    int                 stall;
    int                 exp_id;
    int                 exp_prod;
  } vec_t;

  vec_t tbl[7];

  shift_add_mul_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_prod"},  32'(rsp_prod),  0);
    check({tag, "_rsp_id"},    32'(rsp_id),    0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    n_rst     = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic scramble_operands();
    req_a = NUM_REQ*WIDTH'($urandom);
    req_b = NUM_REQ*WIDTH'($urandom);
  endtask

  // Called at #1 after an edge with the DUT idle and operands already driven.
  task automatic run_txn(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ-1:0] valid_after,
                         input int exp_id, input int exp_prod, input int stall,
                         input logic early_rdy, input logic scramble, input string tag);
    logic [NUM_REQ-1:0] onehot;
    onehot         = '0;
    onehot[exp_id] = 1'b1;
    req_valid      = valid;
    #1;
    check({tag, "_grant"}, 32'(req_ready), 32'(onehot));
    check({tag, "_idle_busy"}, 32'(busy), 0);
    @(posedge clk);
    #1;
    req_valid = valid_after;
    rsp_ready = early_rdy;
    if (scramble) scramble_operands();
    for (int c = 0; c < WIDTH; c++) begin
      check({tag, "_calc_valid"}, 32'(rsp_valid), 0);
      check({tag, "_calc_ready"}, 32'(req_ready), 0);
      check({tag, "_calc_busy"},  32'(busy),      1);
      tick();
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
    check({tag, "_rsp_prod"},  32'(rsp_prod),  32'(exp_prod));
    check({tag, "_rsp_id"},    32'(rsp_id),    32'(exp_id));
    check({tag, "_resp_ready"}, 32'(req_ready), 0);
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      tick();
      check({tag, "_stall_valid"}, 32'(rsp_valid), 1);
      check({tag, "_stall_prod"},  32'(rsp_prod),  32'(exp_prod));
      check({tag, "_stall_id"},    32'(rsp_id),    32'(exp_id));
      check({tag, "_stall_ready"}, 32'(req_ready), 0);
      check({tag, "_stall_busy"},  32'(busy),      1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(rsp_valid), 0);
    check({tag, "_done_prod"},  32'(rsp_prod),  32'(exp_prod));
  endtask

  int qa[NUM_REQ][$];
  int qb[NUM_REQ][$];
  int model_ptr;
  int pending;
  int guard;
  int g;
  logic [NUM_REQ-1:0] v;

  initial begin
    n_rst     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    #3;

    // Reset state, then idle with no requests.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero("idle");
    end

    // Directed vectors; round-robin pointer evolves across entries from 0.
    tbl[0] = '{valid: 4'b0001, a: 15, b: 15, stall: 0, exp_id: 0, exp_prod: 225};
    tbl[1] = '{valid: 4'b0100, a: 7,  b: 9,  stall: 5, exp_id: 2, exp_prod: 63};
    tbl[2] = '{valid: 4'b0010, a: 0,  b: 13, stall: 1, exp_id: 1, exp_prod: 0};
    tbl[3] = '{valid: 4'b1000, a: 13, b: 0,  stall: 0, exp_id: 3, exp_prod: 0};
    tbl[4] = '{valid: 4'b0110, a: 5,  b: 11, stall: 2, exp_id: 1, exp_prod: 55};
    tbl[5] = '{valid: 4'b0011, a: 1,  b: 1,  stall: 0, exp_id: 0, exp_prod: 1};
    tbl[6] = '{valid: 4'b1001, a: 15, b: 1,  stall: 3, exp_id: 3, exp_prod: 15};
    for (int t = 0; t < 7; t++) begin
      scramble_operands();
      req_a[tbl[t].exp_id*WIDTH +: WIDTH] = WIDTH'(tbl[t].a);
      req_b[tbl[t].exp_id*WIDTH +: WIDTH] = WIDTH'(tbl[t].b);
      run_txn(tbl[t].valid, '0, tbl[t].exp_id, tbl[t].exp_prod, tbl[t].stall,
              1'(t % 2), 1'b1, $sformatf("vec%0d", t));
    end

    // All requesters held valid: grants rotate 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(3);
    end
    for (int t = 0; t < 5; t++) begin
      run_txn(4'b1111, 4'b1111, t % NUM_REQ, 3 * ((t % NUM_REQ) + 1), 0, 1'b0, 1'b0,
              $sformatf("rr%0d", t));
    end
    req_valid = '0;
    tick();

    // Reset during CALC with cnt=2 discards the operation.
    req_a = '0;
    req_b = '0;
    req_a[0 +: WIDTH] = WIDTH'(9);
    req_b[0 +: WIDTH] = WIDTH'(9);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    check_all_zero("midcalc_rst");
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_valid", 32'(rsp_valid), 0);
      check("post_rst_busy",  32'(busy),      0);
    end
    req_a[0*WIDTH +: WIDTH] = WIDTH'(3);
    req_b[0*WIDTH +: WIDTH] = WIDTH'(5);
    req_a[1*WIDTH +: WIDTH] = WIDTH'(6);
    req_b[1*WIDTH +: WIDTH] = WIDTH'(7);
    run_txn(4'b0011, '0, 0, 15, 0, 1'b0, 1'b1, "post_rst");

    // Every a,b pair on random requesters, random valid drops and stalls.
    do_reset();
    model_ptr = 0;
    for (int k = 0; k < 256; k++) begin
      g = $urandom_range(0, NUM_REQ - 1);
      qa[g].push_back(k / 16);
      qb[g].push_back(k % 16);
    end
    pending = 256;
    guard   = 0;
    while (pending > 0 && guard < 5000) begin
      guard++;
      scramble_operands();
      v = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (qa[i].size() > 0) begin
          req_a[i*WIDTH +: WIDTH] = WIDTH'(qa[i][0]);
          req_b[i*WIDTH +: WIDTH] = WIDTH'(qb[i][0]);
          v[i] = ($urandom_range(0, 3) != 0);
        end
      end
      if (v == '0) begin
        req_valid = '0;
        #1;
        check("rand_no_grant", 32'(req_ready), 0);
        tick();
        continue;
      end
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (g < 0 && v[(model_ptr + k) % NUM_REQ]) g = (model_ptr + k) % NUM_REQ;
      end
      run_txn(v, '0, g, qa[g][0] * qb[g][0], $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'b1, "rand");
      void'(qa[g].pop_front());
      void'(qb[g].pop_front());
      model_ptr = (g + 1) % NUM_REQ;
      pending--;
    end
    check("rand_all_served", 32'(pending), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
